// File: rtl/proc_fetch_buf_pkg.sv
// Shared definitions for the TinyRV1 fetch buffer: reset PC, slot-state encoding and the decode payload.
package proc_fetch_buf_pkg;

    localparam int unsigned    XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_VALID   = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_slot_ring.sv
// Ring of fetch slots: allocated on request, filled in order by responses, drained in order by decode.
module fetch_slot_ring
    import proc_fetch_buf_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc_en,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             fill_en,
    input  logic [XLEN-1:0]  fill_data,
    input  logic             deq_en,
    output logic             head_val,
    output fetch_pkt_t       head_pkt,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] pend_cnt
);

    slot_state_e      state_q [DEPTH];
    fetch_pkt_t       pkt_q   [DEPTH];
    logic [PTR_W-1:0] alloc_ptr_q;
    logic [PTR_W-1:0] fill_ptr_q;
    logic [PTR_W-1:0] head_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] pend_vec;

    // Alloc, fill and dequeue always target different slots (EMPTY, PENDING, VALID respectively).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= '{default: SLOT_EMPTY};
            pkt_q       <= '{default: '0};
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
        end else if (flush) begin
            state_q     <= '{default: SLOT_EMPTY};
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
        end else begin
            if (alloc_en) begin
                state_q[alloc_ptr_q]  <= SLOT_PENDING;
                pkt_q[alloc_ptr_q].pc <= alloc_pc;
                alloc_ptr_q           <= alloc_ptr_q + PTR_W'(1);
            end
            if (fill_en) begin
                state_q[fill_ptr_q]    <= SLOT_VALID;
                pkt_q[fill_ptr_q].inst <= fill_data;
                fill_ptr_q             <= fill_ptr_q + PTR_W'(1);
            end
            if (deq_en) begin
                state_q[head_ptr_q] <= SLOT_EMPTY;
                head_ptr_q          <= head_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(alloc_en) - CNT_W'(deq_en);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pend
        assign pend_vec[g] = (state_q[g] == SLOT_PENDING);
    end

    assign pend_cnt = CNT_W'($countones(pend_vec));
    assign count    = count_q;
    assign head_val = (state_q[head_ptr_q] == SLOT_VALID);
    assign head_pkt = pkt_q[head_ptr_q];

endmodule

// File: rtl/proc_fetch_buf.sv
// TinyRV1 fetch stage: PC generation, in-order imem requests, response buffering and redirect squash.
module proc_fetch_buf
    import proc_fetch_buf_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_val,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_D,
    output logic            imemreq_val,
    input  logic            imemreq_rdy,
    output logic [XLEN-1:0] imemreq_addr,
    input  logic            imemresp_val,
    input  logic [XLEN-1:0] imemresp_data,
    output logic            val_D,
    output logic [XLEN-1:0] inst_D,
    output logic [XLEN-1:0] pc_D
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] pend_cnt;
    logic [OCC_W-1:0] occ;
    logic             req_fire;
    logic             fill_en;
    logic             deq_en;
    logic             head_val;
    fetch_pkt_t       head_pkt;

    // Stale in-flight fetches still occupy capacity until their responses are dropped.
    assign occ          = OCC_W'(count) + OCC_W'(drop_cnt_q);
    assign imemreq_val  = rst & ~redirect_val & (occ < OCC_W'(DEPTH));
    assign imemreq_addr = pc_q;
    assign req_fire     = imemreq_val & imemreq_rdy;
    assign fill_en      = imemresp_val & ~redirect_val & (drop_cnt_q == '0);
    assign deq_en       = head_val & ~stall_D & ~redirect_val;

    assign val_D  = head_val;
    assign inst_D = head_val ? head_pkt.inst : '0;
    assign pc_D   = head_val ? head_pkt.pc   : '0;

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_val) begin
            pc_d       = redirect_pc;
            drop_cnt_d = CNT_W'(OCC_W'(drop_cnt_q) + OCC_W'(pend_cnt) - OCC_W'(imemresp_val));
        end else begin
            if (req_fire) begin
                pc_d = pc_q + INST_BYTES;
            end
            if (imemresp_val && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_slot_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_val),
        .alloc_en  (req_fire),
        .alloc_pc  (pc_q),
        .fill_en   (fill_en),
        .fill_data (imemresp_data),
        .deq_en    (deq_en),
        .head_val  (head_val),
        .head_pkt  (head_pkt),
        .count     (count),
        .pend_cnt  (pend_cnt)
    );

    resp_orphan_a: assert property (@(posedge clk) disable iff (!rst)
        !(imemresp_val && (pend_cnt == '0) && (drop_cnt_q == '0)))
        else $error("proc_fetch_buf: imem response with nothing outstanding");

endmodule

// File: tb/tb_proc_fetch_buf.sv
// Self-checking bench for proc_fetch_buf: per-cycle vector table plus scoreboard and fixed-latency memory.
module tb_proc_fetch_buf;

    localparam logic [31:0] MEM_BASE = 32'h1000_0000;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic        stall_D;
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic [31:0] imemresp_data;
    logic        val_D;
    logic [31:0] inst_D;
    logic [31:0] pc_D;

    proc_fetch_buf #(
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_val  (redirect_val),
        .redirect_pc   (redirect_pc),
        .stall_D       (stall_D),
        .imemreq_val   (imemreq_val),
        .imemreq_rdy   (imemreq_rdy),
        .imemreq_addr  (imemreq_addr),
        .imemresp_val  (imemresp_val),
        .imemresp_data (imemresp_data),
        .val_D         (val_D),
        .inst_D        (inst_D),
        .pc_D          (pc_D)
    );

    typedef struct {
        bit          rst_before;
        int          lat;
        bit          rdy;
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          exp_req;
        bit          exp_vald;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    mem_t        mq[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_addr = RST_PC;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic add(input bit rb, input int lt, input bit rdy, input bit stall, input bit redir,
                       input logic [31:0] rpc, input bit er, input bit ev);
        vec_t v;
        v.rst_before = rb; v.lat = lt; v.rdy = rdy; v.stall = stall; v.redir = redir;
        v.rpc = rpc; v.exp_req = er; v.exp_vald = ev;
        tbl.push_back(v);
    endtask

    // Memory returns MEM_BASE+addr exactly `lat` cycles after the request is accepted.
    task automatic drive_mem();
        if (mq.size() != 0 && mq[0].due == cyc) begin
            imemresp_val  = 1'b1;
            imemresp_data = mq[0].data;
            void'(mq.pop_front());
        end else begin
            imemresp_val  = 1'b0;
            imemresp_data = '0;
        end
    endtask

    task automatic step(input bit rdy, input bit stall, input bit redir, input logic [31:0] rpc,
                        input bit exp_req, input bit exp_vald);
        logic fire;
        imemreq_rdy  = rdy;
        stall_D      = stall;
        redirect_val = redir;
        redirect_pc  = rpc;
        drive_mem();
        #1;
        chk("req_val", 32'(imemreq_val), 32'(exp_req));
        chk("val_D", 32'(val_D), 32'(exp_vald));
        if (imemreq_val) chk("req_addr", imemreq_addr, exp_addr);
        if (val_D) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: val_D=1 pc_D=0x%08h with nothing expected at cycle %0d", pc_D, cyc);
            end else begin
                chk("pc_D", pc_D, sb[0].pc);
                chk("inst_D", inst_D, sb[0].inst);
                if (!stall && !redir) void'(sb.pop_front());
            end
        end else begin
            chk("pc_D_idle", pc_D, 32'h0);
            chk("inst_D_idle", inst_D, 32'h0);
        end
        fire = imemreq_val & rdy;
        if (redir) begin
            sb.delete();
            exp_addr = rpc;
        end else if (fire) begin
            sb.push_back('{pc: exp_addr, inst: MEM_BASE + exp_addr});
            mq.push_back('{due: cyc + lat, data: MEM_BASE + imemreq_addr});
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset long enough for every in-flight response to drain, then release.
    task automatic do_reset(input int new_lat);
        rst          = 1'b0;
        imemreq_rdy  = 1'b0;
        stall_D      = 1'b0;
        redirect_val = 1'b0;
        redirect_pc  = '0;
        for (int i = 0; i < 6; i++) begin
            drive_mem();
            #1;
            chk("rst_req_val", 32'(imemreq_val), 32'h0);
            chk("rst_val_D", 32'(val_D), 32'h0);
            chk("rst_inst_D", inst_D, 32'h0);
            chk("rst_pc_D", pc_D, 32'h0);
            @(negedge clk);
        end
        sb.delete();
        mq.delete();
        exp_addr = RST_PC;
        lat      = new_lat;
        rst      = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        redirect_val  = 1'b0;
        redirect_pc   = '0;
        stall_D       = 1'b0;
        imemreq_rdy   = 1'b0;
        imemresp_val  = 1'b0;
        imemresp_data = '0;
        #1 rst = 1'b0;

        // Streaming, latency 1: DEPTH=2 without bypass gives two fetches per three cycles.
        add(1,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 0,1);
        add(0,1, 1,0,0,0, 1,1); add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 0,1);
        add(0,1, 1,0,0,0, 1,1); add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 0,1);
        // Decode stall for 4 cycles with both slots full.
        add(1,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 1,0);
        add(0,1, 1,1,0,0, 0,1); add(0,1, 1,1,0,0, 0,1); add(0,1, 1,1,0,0, 0,1); add(0,1, 1,1,0,0, 0,1);
        add(0,1, 1,0,0,0, 0,1); add(0,1, 1,0,0,0, 1,1); add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 0,1);
        // Latency 3, redirect with two requests in flight.
        add(1,3, 1,0,0,0, 1,0); add(0,3, 1,0,0,0, 1,0); add(0,3, 1,0,1,32'h100, 0,0);
        add(0,3, 1,0,0,0, 0,0); add(0,3, 1,0,0,0, 1,0); add(0,3, 1,0,0,0, 1,0);
        add(0,3, 1,0,0,0, 0,0); add(0,3, 1,0,0,0, 0,0); add(0,3, 1,0,0,0, 0,1); add(0,3, 1,0,0,0, 1,1);
        // Memory not ready for 4 cycles while request to 0x8 is pending.
        add(1,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 0,1);
        add(0,1, 0,0,0,0, 1,1); add(0,1, 0,0,0,0, 1,0); add(0,1, 0,0,0,0, 1,0); add(0,1, 0,0,0,0, 1,0);
        add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 0,1);
        // Redirect coinciding with a response and a would-be dequeue.
        add(1,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,1,32'h200, 0,1);
        add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 1,0); add(0,1, 1,0,0,0, 0,1); add(0,1, 1,0,0,0, 1,1);
        // Latency 2: redirect with a same-cycle response and one request still in flight.
        add(1,2, 1,0,0,0, 1,0); add(0,2, 1,0,0,0, 1,0); add(0,2, 1,0,1,32'h300, 0,0);
        add(0,2, 1,0,0,0, 1,0); add(0,2, 1,0,0,0, 1,0); add(0,2, 1,0,0,0, 0,0);
        add(0,2, 1,0,0,0, 0,1); add(0,2, 1,0,0,0, 1,1);

        @(negedge clk);
        foreach (tbl[k]) begin
            if (tbl[k].rst_before) do_reset(tbl[k].lat);
            step(tbl[k].rdy, tbl[k].stall, tbl[k].redir, tbl[k].rpc, tbl[k].exp_req, tbl[k].exp_vald);
        end

        // Asynchronous reset between clock edges, then restart from RESET_PC.
        do_reset(1);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1);
        imemreq_rdy  = 1'b1;
        stall_D      = 1'b0;
        redirect_val = 1'b0;
        drive_mem();
        #1;
        chk("pre_arst_req_val", 32'(imemreq_val), 32'h1);
        chk("pre_arst_val_D", 32'(val_D), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("arst_req_val", 32'(imemreq_val), 32'h0);
        chk("arst_val_D", 32'(val_D), 32'h0);
        chk("arst_inst_D", inst_D, 32'h0);
        chk("arst_pc_D", pc_D, 32'h0);
        @(negedge clk);
        do_reset(1);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
